// File: rtl/act_bank_ring_if.sv
// Producer/consumer bundle for act_bank_ring: write port, commit, read port, release and status.
interface act_bank_ring_if #(
    parameter int TM         = 128,
    parameter int EW         = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_BANKS  = 4
);
    localparam int BW = ($clog2(NUM_BANKS) < 1) ? 1 : $clog2(NUM_BANKS);

    logic                  flush;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [TM*EW-1:0]      wr_data;
    logic [TM-1:0]         wr_strb;
    logic                  wr_commit;
    logic                  wr_ready;
    logic [BW-1:0]         wr_bank;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_release;
    logic                  rd_avail;
    logic [BW-1:0]         rd_bank;
    logic [TM*EW-1:0]      rd_data;
    logic                  rd_valid;
    logic [BW:0]           count;
    logic [1:0]            err;
    logic                  par_err;

    modport master (
        output flush, wr_en, wr_addr, wr_data, wr_strb, wr_commit,
               rd_en, rd_addr, rd_release,
        input  wr_ready, wr_bank, rd_avail, rd_bank, rd_data, rd_valid,
               count, err, par_err
    );

    modport slave (
        input  flush, wr_en, wr_addr, wr_data, wr_strb, wr_commit,
               rd_en, rd_addr, rd_release,
        output wr_ready, wr_bank, rd_avail, rd_bank, rd_data, rd_valid,
               count, err, par_err
    );
endinterface

// File: rtl/act_bank_ring.sv
// Ring of NUM_BANKS activation tiles with commit/release ownership and a 2-cycle read pipeline.
// Define ACT_BANK_PARITY_EN to store per-element even parity and pulse par_err on bad reads.
module act_bank_ring #(
    parameter int TM         = 128,
    parameter int EW         = 8,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_BANKS  = 4
) (
    input logic            clk,
    input logic            rst_n,
    act_bank_ring_if.slave bus
);
    localparam int BW    = ($clog2(NUM_BANKS) < 1) ? 1 : $clog2(NUM_BANKS);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int DW    = TM * EW;
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [BW:0]   FULL      = (BW + 1)'(NUM_BANKS);

    logic [BW-1:0] wr_ptr, rd_ptr;
    logic [BW:0]   count_q;
    logic [1:0]    err_q;
    logic          wr_ready_w, rd_avail_w;
    logic          wr_fire, commit_fire, rd_fire, release_fire;

    logic [DW-1:0] mem [NUM_BANKS][DEPTH];
    logic [DW-1:0] rd_row_q;
    logic [DW-1:0] rd_data_q;
    logic          s1_valid, rd_valid_q;

    function automatic logic [BW-1:0] bump(input logic [BW-1:0] p);
        return (p == LAST_BANK) ? '0 : p + 1'b1;
    endfunction

    assign wr_ready_w   = (count_q != FULL);
    assign rd_avail_w   = (count_q != '0);
    assign wr_fire      = !bus.flush && bus.wr_en      && wr_ready_w;
    assign commit_fire  = !bus.flush && bus.wr_commit  && wr_ready_w;
    assign rd_fire      = !bus.flush && bus.rd_en      && rd_avail_w;
    assign release_fire = !bus.flush && bus.rd_release && rd_avail_w;

    assign bus.wr_ready = wr_ready_w;
    assign bus.rd_avail = rd_avail_w;
    assign bus.wr_bank  = wr_ptr;
    assign bus.rd_bank  = rd_ptr;
    assign bus.count    = count_q;
    assign bus.err      = err_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            err_q   <= '0;
        end else begin
            if (commit_fire)  wr_ptr <= bump(wr_ptr);
            if (release_fire) rd_ptr <= bump(rd_ptr);
            // A simultaneous commit and release leaves the occupancy unchanged.
            if (commit_fire && !release_fire)
                count_q <= count_q + 1'b1;
            else if (release_fire && !commit_fire)
                count_q <= count_q - 1'b1;
            if ((bus.wr_en || bus.wr_commit) && !wr_ready_w)  err_q[0] <= 1'b1;
            if ((bus.rd_en || bus.rd_release) && !rd_avail_w) err_q[1] <= 1'b1;
        end
    end

    // SRAM array and its read stage carry no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < TM; i++) begin
                if (bus.wr_strb[i])
                    mem[wr_ptr][bus.wr_addr][i*EW +: EW] <= bus.wr_data[i*EW +: EW];
            end
        end
        if (rd_fire)
            rd_row_q <= mem[rd_ptr][bus.rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid   <= rd_fire;
            rd_valid_q <= s1_valid && !bus.flush;
            if (s1_valid && !bus.flush)
                rd_data_q <= rd_row_q;
        end
    end

`ifdef ACT_BANK_PARITY_EN
    logic [TM-1:0] mem_par [NUM_BANKS][DEPTH];
    logic [TM-1:0] rd_par_q;
    logic          par_bad;
    logic          par_err_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int unsigned i = 0; i < TM; i++) begin
                if (bus.wr_strb[i])
                    mem_par[wr_ptr][bus.wr_addr][i] <= ^bus.wr_data[i*EW +: EW];
            end
        end
        if (rd_fire)
            rd_par_q <= mem_par[rd_ptr][bus.rd_addr];
    end

    always_comb begin
        par_bad = 1'b0;
        for (int unsigned i = 0; i < TM; i++) begin
            if ((^rd_row_q[i*EW +: EW]) != rd_par_q[i])
                par_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_err_q <= 1'b0;
        else
            par_err_q <= s1_valid && !bus.flush && par_bad;
    end

    assign bus.par_err = par_err_q;
`else
    assign bus.par_err = 1'b0;
`endif
endmodule
